// File: rtl/alu_mc_pkg.sv
// Shared ALU op codes, FSM state encoding and default width for alu_mc.
// The optional multiplier is enabled by defining ALU_MUL_EN.
package alu_mc_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mc_addsub.sv
// WIDTH-bit adder/subtractor with 4-bit group carry-lookahead.
// Exposes the carry into and out of the MSB so the caller can form signed overflow.
module alu_mc_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c_msb,
  output logic             c_out
);

  localparam int GRP = 4;
  localparam int NG  = (WIDTH + GRP - 1) / GRP;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;

  assign bx = sub ? ~b : b;
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Group carries are resolved first; bit carries then ripple only inside a group.
  always_comb begin
    logic gg;
    logic gp;
    gc    = '0;
    c     = '0;
    gc[0] = sub;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        if (k * GRP + j < WIDTH) begin
          gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
          gp = gp & p[k*GRP+j];
        end
      end
      gc[k+1] = gg | (gp & gc[k]);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GRP == 0) c[i] = gc[i/GRP];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum   = p ^ c[WIDTH-1:0];
  assign c_msb = c[WIDTH-1];
  assign c_out = gc[NG];

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: registered result, valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 1000).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             ovf_reg;
  logic             cout_reg;
  logic             zero_reg;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] mul_sum;

  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_c_msb;
  logic             as_c_out;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_cout;
  logic             alu_zero;

  assign in_ready = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign as_sub = (ALUop == OPW'(OP_SUB)) | (ALUop == OPW'(OP_SLT)) | (ALUop == OPW'(OP_SLTU));

  alu_mc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (A),
    .b     (B),
    .sub   (as_sub),
    .sum   (as_sum),
    .c_msb (as_c_msb),
    .c_out (as_c_out)
  );

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_zero = 1'b0;
    case (ALUop)
      OPW'(OP_AND): alu_res = A & B;
      OPW'(OP_OR):  alu_res = A | B;
      OPW'(OP_XOR): alu_res = A ^ B;
      OPW'(OP_NOR): alu_res = ~(A | B);
      OPW'(OP_ADD), OPW'(OP_SUB): begin
        alu_res  = as_sum;
        alu_ovf  = as_c_msb ^ as_c_out;
        alu_cout = as_c_out;
        alu_zero = (as_sum == '0);
      end
      OPW'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ (as_c_msb ^ as_c_out)};
      OPW'(OP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, ~as_c_out};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign is_mul   = (ALUop == OPW'(OP_MUL));
  assign mul_last = (cnt_reg == CNT_W'(WIDTH - 1));
  assign mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // One multiplier bit per cycle; only the low WIDTH bits of the product are kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (accept && is_mul) begin
      mcand_reg  <= A;
      mplier_reg <= B;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == ST_BUSY) begin
      acc_reg    <= mul_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
  assign mul_sum  = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      ovf_reg       <= 1'b0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        state_reg     <= ST_BUSY;
        out_valid_reg <= 1'b0;
      end else begin
        state_reg     <= ST_DONE;
        out_valid_reg <= 1'b1;
        result_reg    <= alu_res;
        ovf_reg       <= alu_ovf;
        cout_reg      <= alu_cout;
        zero_reg      <= alu_zero;
      end
    end else begin
      case (state_reg)
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_last) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= mul_sum;
            ovf_reg       <= 1'b0;
            cout_reg      <= 1'b0;
            zero_reg      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign Result    = result_reg;
  assign Overflow  = ovf_reg;
  assign CarryOut  = cout_reg;
  assign Zero      = zero_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc; covers the multiplier only when ALU_MUL_EN is defined.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         carryout;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .ALUop     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .Overflow  (overflow),
    .CarryOut  (carryout),
    .Zero      (zero)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge, then withdraw in_valid.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    aluop    = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    $display("txn op=%b a=%h b=%h in_ready=%b", op, va, vb, in_ready);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic c, input logic z);
    chk1({tag, ".ovf"}, overflow, v);
    chk1({tag, ".carry"}, carryout, c);
    chk1({tag, ".zero"}, zero, z);
  endtask

  initial begin
    logic early;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    aluop     = 4'b0000;
    step();
    step();
    chk1("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 32'h0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    #1;
    chk1("rst.in_ready", in_ready, 1'b1);

    issue(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    chk1("add.valid", out_valid, 1'b1);
    chk("add.result", result, 32'h80000000);
    chk_flags("add", 1'b1, 1'b0, 1'b0);
    step();
    chk1("add.drain", out_valid, 1'b0);

    issue(4'b0110, 32'd5, 32'd5);
    chk("sub.result", result, 32'h0);
    chk_flags("sub", 1'b0, 1'b1, 1'b1);

    issue(4'b0111, 32'hFFFFFFFF, 32'd1);
    chk("slt.result", result, 32'd1);
    chk_flags("slt", 1'b0, 1'b0, 1'b0);

    issue(4'b0101, 32'hFFFFFFFF, 32'd1);
    chk("sltu.result", result, 32'd0);

    issue(4'b0000, 32'h0000F0F0, 32'h00000FF0);
    chk("and.result", result, 32'h000000F0);
    issue(4'b0011, 32'hA5A5A5A5, 32'hFFFF0000);
    chk("xor.result", result, 32'h5A5AA5A5);
    issue(4'b0100, 32'h00000000, 32'h0000000F);
    chk("nor.result", result, 32'hFFFFFFF0);
    step();

    // Backpressure: result must hold while new inputs wait.
    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4);
    aluop    = 4'b0001;
    a        = 32'd1;
    b        = 32'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.result", result, 32'd7);
      chk1("bp.valid", out_valid, 1'b1);
      chk1("bp.in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk1("b2b.in_ready", in_ready, 1'b1);
    $display("txn op=0001 a=00000001 b=00000002 back-to-back");
    step();
    in_valid = 1'b0;
    chk1("b2b.valid", out_valid, 1'b1);
    chk("b2b.result", result, 32'd3);

    issue(4'b0010, 32'hFFFFFFFF, 32'd1);
    chk_flags("addc", 1'b0, 1'b1, 1'b1);
    issue(4'b1111, 32'd5, 32'd5);
    chk1("undef.valid", out_valid, 1'b1);
    chk("undef.result", result, 32'h0);
    chk_flags("undef", 1'b0, 1'b0, 1'b0);
    step();

`ifdef ALU_MUL_EN
    issue(4'b1000, 32'h00010001, 32'h0000FFFF);
    chk1("mul.busy_valid", out_valid, 1'b0);
    chk1("mul.busy_ready", in_ready, 1'b0);
    early = 1'b0;
    for (int i = 1; i < W; i++) begin
      step();
      if (out_valid) early = 1'b1;
    end
    chk1("mul.early", early, 1'b0);
    step();
    chk1("mul.valid", out_valid, 1'b1);
    chk("mul.result", result, 32'hFFFFFFFF);
    step();
    issue(4'b1000, 32'h00010001, 32'h0000FFFF);
    for (int i = 0; i < 9; i++) step();
    resetn = 1'b0;
    #1;
    chk1("mulabort.valid", out_valid, 1'b0);
    chk("mulabort.result", result, 32'h0);
    step();
    resetn = 1'b1;
    #1;
    chk1("mulabort.in_ready", in_ready, 1'b1);
`else
    issue(4'b0010, 32'd10, 32'd20);
    issue(4'b1000, 32'd3, 32'd4);
    chk1("nomul.valid", out_valid, 1'b1);
    chk("nomul.result", result, 32'h0);
    step();
`endif

    // Reset asserted while a result is waiting for the consumer.
    early     = 1'b0;
    out_ready = 1'b0;
    issue(4'b0010, 32'd9, 32'd9);
    chk("mid.result", result, 32'd18);
    resetn = 1'b0;
    #1;
    chk1("mid.valid", out_valid, 1'b0);
    chk("mid.rst_result", result, 32'h0);
    step();
    resetn    = 1'b1;
    out_ready = 1'b1;
    #1;
    chk1("mid.in_ready", in_ready, 1'b1);
    issue(4'b0010, 32'd1, 32'd1);
    chk("post.result", result, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
